// File: rtl/array_key_scan.sv
// -----------------------------------------------------------------------------
// array_key_scan
// 4x4 matrix keypad scanner. One row is driven low per scan tick, the columns
// are sampled through a 2-FF synchronizer, and a whole frame (4 ticks) is
// classified as NONE / SINGLE(code) / MULTI. Presses and releases are accepted
// only after DEBOUNCE_FRAMES consecutive frames agree.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   col_n[3:0] in   keypad columns, active-low, asynchronous to clk
//   row_n[3:0] out  keypad rows, one-hot active-low
//   key_code   out  last accepted key code (row*4+col)
//   key_valid  out  one-clk strobe when a new press is accepted
//   key_down   out  debounced "accepted key still held"
//   multi_key  out  more than one key seen in the last completed frame
//
// Debounce FSM
//   state           | meaning
//   ST_RELEASED     | no key accepted, waiting for a single key
//   ST_PRESS_WAIT   | same single key seen frame_cnt frames, not yet accepted
//   ST_PRESSED      | key_code accepted and still held
//   ST_RELEASE_WAIT | accepted key missing for frame_cnt frames
// -----------------------------------------------------------------------------
module array_key_scan #(
  parameter int CLK_DIV         = 2500,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       multi_key
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int FC_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [FC_W-1:0]  FC_DONE  = FC_W'(DEBOUNCE_FRAMES);
  localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
  localparam bit               D_ONE    = (DEBOUNCE_FRAMES == 1);

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_s_q, col_s_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [15:0]      acc_q, acc_d;
  logic [15:0]      frame_q, frame_d;
  logic             frame_done_q, frame_done_d;
  state_t           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_down_q, key_down_d;
  logic             multi_key_q, multi_key_d;

  logic             tick;
  logic [15:0]      acc_sample;
  logic             seen;
  logic             is_multi;
  logic             is_single;
  logic [3:0]       one_code;
  logic [FC_W-1:0]  fc_inc;

  // ---------------------------------------------------------------------------
  // Tick divider, column synchronizer and row scan / frame accumulation
  // ---------------------------------------------------------------------------
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    col_meta_d   = col_n;
    col_s_d      = col_meta_q;
    row_idx_d    = row_idx_q;
    acc_d        = acc_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    acc_sample   = acc_q;
    acc_sample[{row_idx_q, 2'b00} +: 4] = ~col_s_q;
    if (tick) begin
      row_idx_d = row_idx_q + 2'd1;
      if (row_idx_q == 2'd3) begin
        // Last row of the frame: hand the full frame over and start clean.
        frame_d      = acc_sample;
        acc_d        = '0;
        frame_done_d = 1'b1;
      end else begin
        acc_d = acc_sample;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame classification (NONE / SINGLE / MULTI)
  // ---------------------------------------------------------------------------
  always_comb begin
    seen     = 1'b0;
    is_multi = 1'b0;
    one_code = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_q[i]) begin
        if (seen) is_multi = 1'b1;
        seen     = 1'b1;
        one_code = 4'(i);
      end
    end
    is_single = seen & ~is_multi;
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM, evaluated once per completed frame
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    frame_cnt_d = frame_cnt_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    multi_key_d = multi_key_q;
    fc_inc      = frame_cnt_q + FC_ONE;
    if (frame_done_q) begin
      multi_key_d = is_multi;
      case (state_q)
        ST_RELEASED: begin
          if (is_single) begin
            cand_d = one_code;
            if (D_ONE) begin
              key_code_d  = one_code;
              key_down_d  = 1'b1;
              key_valid_d = 1'b1;
              frame_cnt_d = '0;
              state_d     = ST_PRESSED;
            end else begin
              frame_cnt_d = FC_ONE;
              state_d     = ST_PRESS_WAIT;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (is_single && (one_code == cand_q)) begin
            if (fc_inc == FC_DONE) begin
              key_code_d  = cand_q;
              key_down_d  = 1'b1;
              key_valid_d = 1'b1;
              frame_cnt_d = '0;
              state_d     = ST_PRESSED;
            end else begin
              frame_cnt_d = fc_inc;
            end
          end else if (is_single) begin
            cand_d      = one_code;
            frame_cnt_d = FC_ONE;
          end else begin
            frame_cnt_d = '0;
            state_d     = ST_RELEASED;
          end
        end
        ST_PRESSED: begin
          // A rollover (MULTI) or a different single key counts as "not held".
          if (!(is_single && (one_code == key_code_q))) begin
            if (D_ONE) begin
              key_down_d  = 1'b0;
              frame_cnt_d = '0;
              state_d     = ST_RELEASED;
            end else begin
              frame_cnt_d = FC_ONE;
              state_d     = ST_RELEASE_WAIT;
            end
          end
        end
        ST_RELEASE_WAIT: begin
          if (is_single && (one_code == key_code_q)) begin
            frame_cnt_d = '0;
            state_d     = ST_PRESSED;
          end else if (fc_inc == FC_DONE) begin
            key_down_d  = 1'b0;
            frame_cnt_d = '0;
            state_d     = ST_RELEASED;
          end else begin
            frame_cnt_d = fc_inc;
          end
        end
        default: begin
          frame_cnt_d = '0;
          state_d     = ST_RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      col_meta_q   <= 4'hF;
      col_s_q      <= 4'hF;
      row_idx_q    <= '0;
      acc_q        <= '0;
      frame_q      <= '0;
      frame_done_q <= 1'b0;
      state_q      <= ST_RELEASED;
      cand_q       <= '0;
      frame_cnt_q  <= '0;
      key_code_q   <= '0;
      key_valid_q  <= 1'b0;
      key_down_q   <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      col_meta_q   <= col_meta_d;
      col_s_q      <= col_s_d;
      row_idx_q    <= row_idx_d;
      acc_q        <= acc_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      frame_cnt_q  <= frame_cnt_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_down_q   <= key_down_d;
      multi_key_q  <= multi_key_d;
    end
  end

  assign row_n     = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_array_key_scan.sv
// -----------------------------------------------------------------------------
// tb_array_key_scan
// Bench for array_key_scan with CLK_DIV=4, DEBOUNCE_FRAMES=3. A keypad model
// closes row/column contacts from a 16-bit key set that changes only on frame
// boundaries. The reference model works per frame: it keeps the recent frame
// classifications and accepts a press (or release) once the last three frames
// since the previous event all agree.
// -----------------------------------------------------------------------------
module tb_array_key_scan;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;
  localparam int FRAME   = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic        multi_key;
  logic [15:0] keys = '0;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_down;
  bit          m_multi;
  bit          m_valid;
  logic [3:0]  m_code;
  int          m_accepts;
  int          hist[$];
  bit          have_prev;
  logic [15:0] prev_keys;
  int          n_pulses = 0;

  array_key_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .multi_key (multi_key)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  always @(negedge clk) if (rst_n && key_valid) n_pulses++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int classify(input logic [15:0] k);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 16; i++) if (k[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return idx;
  endfunction

  task automatic model_reset();
    m_down = 0; m_multi = 0; m_valid = 0; m_code = '0;
    hist.delete();
    have_prev = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int c;
    bit hit;
    c = classify(k);
    m_multi = (c == -2);
    m_valid = 0;
    hist.push_back(c);
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      if (!m_down) begin
        hit = (c >= 0);
        foreach (hist[i]) if (hist[i] != c) hit = 0;
        if (hit) begin
          m_down = 1; m_code = 4'(c); m_valid = 1; m_accepts++;
          hist.delete();
        end
      end else begin
        hit = 1;
        foreach (hist[i]) if (hist[i] == int'(m_code)) hit = 0;
        if (hit) begin
          m_down = 0;
          hist.delete();
        end
      end
    end
  endtask

  task automatic check_outs(input string where, input bit exp_valid);
    check_val({where, ":key_valid"}, key_valid, exp_valid);
    check_val({where, ":key_down"},  key_down,  m_down);
    check_val({where, ":key_code"},  key_code,  m_code);
    check_val({where, ":multi_key"}, multi_key, m_multi);
  endtask

  // Entered on the negedge of the first cycle of a frame; leaves on the
  // negedge of the first cycle of the next frame.
  task automatic run_frame(input logic [15:0] k);
    logic [3:0] exp_row;
    check_outs("frame_start", 1'b0);
    check_val("row_n", row_n, 4'b1110);
    if (have_prev) model_frame(prev_keys);
    keys      = k;
    prev_keys = k;
    have_prev = 1;
    for (int i = 1; i < FRAME; i++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << (i / CLK_DIV));
      check_val("row_n", row_n, exp_row);
      if (i == 1) check_outs("frame_update", m_valid);
      else if (i == 2 || i == 9) check_outs("frame_hold", 1'b0);
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [15:0] k, input int frames);
    for (int f = 0; f < frames; f++) run_frame(k);
  endtask

  task automatic check_reset_outs(input string where);
    check_val({where, ":row_n"},     row_n,     4'b1110);
    check_val({where, ":key_code"},  key_code,  4'h0);
    check_val({where, ":key_valid"}, key_valid, 1'b0);
    check_val({where, ":key_down"},  key_down,  1'b0);
    check_val({where, ":multi_key"}, multi_key, 1'b0);
  endtask

  task automatic reset_mid_frame();
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [15:0] pat;
    int a, b, len;
    model_reset();
    m_accepts = 0;
    #1 check_reset_outs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    hold(16'h0000, 4);                      // idle scan
    hold(16'h0040, 10);                     // key(1,2) -> code 6
    hold(16'h0000, 5);
    for (int r = 0; r < 5; r++) begin       // bouncing key(0,3)
      hold(16'h0008, 2);
      hold(16'h0000, 1);
    end
    hold(16'h0000, 4);
    hold(16'h1200, 4);                      // key(2,1)+key(3,0) rollover
    hold(16'h0200, 6);                      // only key 9 left
    hold(16'h0000, 5);
    hold(16'h0040, 5);                      // accept key 6, then reset
    reset_mid_frame();
    hold(16'h0040, 6);
    hold(16'h0000, 5);
    hold(16'h0040, 5);                      // key 6 then straight to key 15
    hold(16'h8000, 8);
    hold(16'h0000, 5);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: pat = '0;
        9: begin
          a = $urandom_range(0, 15);
          b = (a + 1 + $urandom_range(0, 14)) % 16;
          pat = (16'(1) << a) | (16'(1) << b);
        end
        default: pat = 16'(1) << $urandom_range(0, 15);
      endcase
      len = $urandom_range(1, 5);
      hold(pat, len);
    end
    hold(16'h0000, 5);

    check_val("valid_pulse_count", n_pulses, m_accepts);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
